cmd_uart_wrapper: RTL and testbench

- Robot-side end of the remote command link; RemoteComm is the host-side end.
- Receives the host's 16-bit command over an 8N1 UART as two bytes, high byte first, and presents it to the command processor as `cmd` with a `cmd_rdy` flag.
- Transmits the processor's 8-bit response (e.g. 8'hA5 positive ack) back over TX.
- Contains its own UART receiver, UART transmitter and byte-assembly FSM; sits between the RX/TX pins and the command processor inside KnightsTour.

---
 rtl/cmd_uart_wrapper.sv | 160 ++++++++++++++++
 tb/tb_cmd_uart_wrapper.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_uart_wrapper.sv
// Robot-side end of the host command link: 8N1 UART receiver that assembles two
// bytes (high first) into a 16-bit command, plus a UART transmitter for the response.
module cmd_uart_wrapper #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] LP_FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] LP_HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] LP_ONE  = CW'(1);

  typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
  typedef enum logic {ASM_HIGH, ASM_LOW} asm_state_t;
  typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;

  rx_state_t   r_rx_state;
  logic        r_rx_meta, r_rx_sync, r_rx_prev;
  logic [CW-1:0] r_rx_cnt;
  logic [3:0]  r_rx_bits;
  logic [7:0]  r_rx_shift;

  asm_state_t  r_asm_state;
  logic [7:0]  r_held;

  tx_state_t   r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0]  r_tx_bits;
  logic [8:0]  r_tx_shift;

  logic w_start, w_tick, w_rx_done, w_set, w_clr;

  assign w_start   = (r_rx_state == RX_IDLE) && r_rx_prev && !r_rx_sync;
  assign w_tick    = (r_rx_state == RX_RECV) && (r_rx_cnt == '0);
  assign w_rx_done = w_tick && (r_rx_bits == 4'd9) && r_rx_sync;
  assign w_set     = w_rx_done && (r_asm_state == ASM_LOW);
  assign w_clr     = clr_cmd_rdy || (w_start && (r_asm_state == ASM_HIGH));

  // Receiver: start-bit edge on the synchronized line, then 10 mid-bit samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bits  <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_meta <= RX;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      case (r_rx_state)
        RX_IDLE: begin
          if (w_start) begin
            r_rx_state <= RX_RECV;
            r_rx_cnt   <= LP_HALF;
            r_rx_bits  <= '0;
          end
        end
        RX_RECV: begin
          if (r_rx_cnt != '0) begin
            r_rx_cnt <= r_rx_cnt - LP_ONE;
          end else begin
            r_rx_cnt  <= LP_FULL;
            r_rx_bits <= r_rx_bits + 4'd1;
            if (r_rx_bits == 4'd0 && r_rx_sync)
              r_rx_state <= RX_IDLE;
            else if (r_rx_bits == 4'd9)
              r_rx_state <= RX_IDLE;
            else if (r_rx_bits != 4'd0)
              r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // Byte assembly; clearing cmd_rdy takes priority over setting it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_asm_state <= ASM_HIGH;
      r_held      <= '0;
      cmd         <= '0;
      cmd_rdy     <= 1'b0;
    end else begin
      if (w_rx_done) begin
        case (r_asm_state)
          ASM_HIGH: begin
            r_held      <= r_rx_shift;
            r_asm_state <= ASM_LOW;
          end
          ASM_LOW: begin
            cmd         <= {r_held, r_rx_shift};
            r_asm_state <= ASM_HIGH;
          end
          default: r_asm_state <= ASM_HIGH;
        endcase
      end
      if (w_clr)
        cmd_rdy <= 1'b0;
      else if (w_set)
        cmd_rdy <= 1'b1;
    end
  end

  // Transmitter: start bit driven on acceptance, then 9 remaining bits LSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bits  <= '0;
      r_tx_shift <= '1;
      TX         <= 1'b1;
      resp_sent  <= 1'b0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (send_resp) begin
            r_tx_shift <= {1'b1, resp};
            TX         <= 1'b0;
            resp_sent  <= 1'b0;
            r_tx_cnt   <= LP_FULL;
            r_tx_bits  <= '0;
            r_tx_state <= TX_XMIT;
          end
        end
        TX_XMIT: begin
          if (r_tx_cnt != '0) begin
            r_tx_cnt <= r_tx_cnt - LP_ONE;
          end else begin
            r_tx_cnt <= LP_FULL;
            if (r_tx_bits == 4'd9) begin
              TX         <= 1'b1;
              resp_sent  <= 1'b1;
              r_tx_state <= TX_IDLE;
            end else begin
              TX         <= r_tx_shift[0];
              r_tx_shift <= {1'b1, r_tx_shift[8:1]};
              r_tx_bits  <= r_tx_bits + 4'd1;
            end
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_uart_wrapper.sv
// Scoreboard bench for cmd_uart_wrapper: host-side UART driver plus monitors for
// assembled commands and transmitted response frames.
module tb_cmd_uart_wrapper;
  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst_n, RX, TX, cmd_rdy, clr_cmd_rdy, send_resp, resp_sent;
  logic [15:0] cmd;
  logic [7:0]  resp;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int stop_cyc = 0;
  int rise_cyc = 0;

  logic [15:0] cmd_q[$];
  logic [7:0]  resp_q[$];

  cmd_uart_wrapper #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp), .resp_sent(resp_sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BD) @(negedge clk);
    end
    RX = stop;
    stop_cyc = cyc;
    repeat (BD) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic pulse_send(input logic [7:0] v);
    @(negedge clk);
    resp = v;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  // Command monitor: every rising cmd_rdy must match the next expected command.
  initial begin : cmd_mon
    logic prev;
    logic [15:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (cmd_rdy && !prev) begin
          rise_cyc = cyc;
          if (cmd_q.size() == 0) begin
            total++; bad++;
            $display("FAIL cmd_unexpected: got %0h want none", cmd);
          end else begin
            e = cmd_q.pop_front();
            chk("cmd", {16'h0, cmd}, {16'h0, e});
          end
        end
        prev = cmd_rdy;
      end
    end
  end

  // TX monitor: decodes each frame, checks bit hold times and resp_sent timing.
  initial begin : tx_mon
    logic [9:0] bits;
    logic hold_bad, aborted, rs_start, rs_before, rs_at;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && TX == 1'b0) begin
        aborted = 1'b0; hold_bad = 1'b0; bits = '0;
        rs_start = resp_sent; rs_before = 1'b0;
        for (int b = 0; b < 10; b++) begin
          for (int c = 0; c < BD; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk);
            if (!rst_n) aborted = 1'b1;
            if (!aborted) begin
              if (c == 0) bits[b] = TX;
              else if (TX !== bits[b]) hold_bad = 1'b1;
              if (b == 9 && c == BD - 1) rs_before = resp_sent;
            end
          end
        end
        if (!aborted) begin
          @(negedge clk);
          rs_at = resp_sent;
          chk("tx_start_bit", {31'h0, bits[0]}, 32'h0);
          chk("tx_stop_bit", {31'h0, bits[9]}, 32'h1);
          chk("tx_bit_hold", {31'h0, hold_bad}, 32'h0);
          chk("resp_sent_clr_in_frame", {29'h0, rs_start, rs_before, 1'b0}, 32'h0);
          chk("resp_sent_at_10bd", {31'h0, rs_at}, 32'h1);
          if (resp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL tx_unexpected: got %0h want none", bits[8:1]);
          end else begin
            e = resp_q.pop_front();
            chk("tx_data", {24'h0, bits[8:1]}, {24'h0, e});
          end
        end
      end
    end
  end

  initial begin : stim
    int d;
    rst_n = 1'b0; RX = 1'b1; clr_cmd_rdy = 1'b0; send_resp = 1'b0; resp = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_TX", {31'h0, TX}, 32'h1);
    chk("rst_cmd", {16'h0, cmd}, 32'h0);
    chk("rst_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
    chk("rst_resp_sent", {31'h0, resp_sent}, 32'h0);
    rst_n = 1'b1;
    idle(2 * BD);

    // Basic command 0x43F1, latency and clear
    cmd_q.push_back(16'h43F1);
    send_byte(8'h43, 1'b1);
    idle(BD);
    send_byte(8'hF1, 1'b1);
    d = rise_cyc - stop_cyc;
    chk("rdy_latency_window", {31'h0, (d >= 1 && d <= BD)}, 32'h1);
    pulse_clr();
    chk("clr_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
    chk("cmd_held_after_clr", {16'h0, cmd}, 32'h43F1);
    idle(BD);

    // Response 0xA5, with a second send_resp mid-frame that must be ignored
    resp_q.push_back(8'hA5);
    pulse_send(8'hA5);
    resp = 8'h3C;
    repeat (3 * BD) @(negedge clk);
    pulse_send(8'h3C);
    repeat (8 * BD) @(negedge clk);

    // Full duplex: command 0x2000 received while 0xA5 is transmitted
    cmd_q.push_back(16'h2000);
    resp_q.push_back(8'hA5);
    fork
      begin send_byte(8'h20, 1'b1); send_byte(8'h00, 1'b1); end
      begin repeat (2 * BD) @(negedge clk); pulse_send(8'hA5); end
    join
    idle(10 * BD);
    pulse_clr();

    // Glitch rejected as false start, then 0x12 0x34
    @(negedge clk);
    RX = 1'b0;
    repeat (BD / 4) @(negedge clk);
    idle(2 * BD);
    cmd_q.push_back(16'h1234);
    send_byte(8'h12, 1'b1);
    idle(BD);
    send_byte(8'h34, 1'b1);
    idle(BD);

    // New start bit in HIGH clears cmd_rdy; cmd kept until second byte
    cmd_q.push_back(16'h5678);
    send_byte(8'h56, 1'b1);
    chk("start_clears_rdy", {31'h0, cmd_rdy}, 32'h0);
    chk("cmd_kept_first_byte", {16'h0, cmd}, 32'h1234);
    idle(BD);
    send_byte(8'h78, 1'b1);
    pulse_clr();
    idle(BD);

    // Framing error discarded
    cmd_q.push_back(16'h1234);
    send_byte(8'h55, 1'b0);
    idle(2 * BD);
    send_byte(8'h12, 1'b1);
    idle(BD);
    send_byte(8'h34, 1'b1);
    idle(BD);

    // Asynchronous reset mid RX byte and mid TX frame
    send_byte(8'hBE, 1'b1);
    pulse_send(8'h00);
    @(negedge clk);
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RX = 1'b1 ^ (i[0]);
      repeat (BD) @(negedge clk);
    end
    chk("tx_low_before_rst", {31'h0, TX}, 32'h0);
    #3 rst_n = 1'b0;
    RX = 1'b1;
    #1;
    chk("async_rst_TX", {31'h0, TX}, 32'h1);
    chk("async_rst_cmd", {16'h0, cmd}, 32'h0);
    chk("async_rst_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2 * BD);
    cmd_q.push_back(16'h4BF1);
    send_byte(8'h4B, 1'b1);
    idle(BD);
    send_byte(8'hF1, 1'b1);
    pulse_clr();

    for (int i = 0; i < 20 * BD && (cmd_q.size() != 0 || resp_q.size() != 0); i++)
      @(negedge clk);
    idle(12 * BD);
    chk("cmd_q_drained", cmd_q.size(), 32'h0);
    chk("resp_q_drained", resp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #(2_000_000);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
